cycle_profiler: RTL and testbench
=================================

CYCLE_PROFILER -- requirements
Module: cycle_profiler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of profiled requester channels (2..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of timebase and results.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of result entries (power of 2).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 freeze  input  1  when 1, timebase holds its value.
REQ-007 start  input  NUM_CH  per-channel one-cycle start pulse.
REQ-008 done  input  NUM_CH  per-channel one-cycle done pulse.
REQ-009 res_valid  output  1  result entry available at FIFO head.
REQ-010 res_ready  input  1  consumer accepts head entry when res_valid is also 1.
REQ-011 res_ch  output  clog2(NUM_CH)  channel index of head entry.
REQ-012 res_ticks  output  CNT_W  elapsed timebase ticks of head entry.
REQ-013 proto_err  output  NUM_CH  sticky per-channel protocol-error flags.
REQ-014 tick_now  output  CNT_W  current timebase value.

Function
REQ-015 Timebase SHALL increment by 1 each cycle with freeze=0, hold with freeze=1, and wrap modulo 2^CNT_W.
REQ-016 Each channel SHALL run an FSM with states IDLE, RUN, PEND.
REQ-017 IDLE->RUN on start=1; SHALL capture tick_now of that cycle as the channel timestamp.
REQ-018 RUN->PEND on done=1; SHALL store latency = (tick_now - timestamp) mod 2^CNT_W.
REQ-019 IDLE with start=1 and done=1 in the same cycle SHALL go directly to PEND with latency 0.
REQ-020 PEND->IDLE SHALL occur on the cycle the channel is granted a FIFO write.
REQ-021 start in RUN or PEND, and done in IDLE (start=0) or PEND, SHALL be ignored and SHALL set that channel's proto_err bit.
REQ-022 freeze SHALL NOT block channel events; frozen cycles are excluded from latency.
REQ-023 Arbiter SHALL grant at most one PEND channel per cycle, round-robin, with search beginning at (last granted + 1) mod NUM_CH.
REQ-024 A grant SHALL be issued only when FIFO occupancy < FIFO_DEPTH at the start of the cycle; a same-cycle pop does not enable a push.
REQ-025 A granted entry {ch, latency} SHALL be written on the grant edge; res_valid SHALL be 1 from the next cycle.
REQ-026 Minimum latency SHALL be: done in cycle k -> PEND at k+1 -> grant at k+1 -> res_valid at k+2.
REQ-027 FIFO SHALL pop on res_valid & res_ready and SHALL support simultaneous push and pop when not full.
REQ-028 res_ch/res_ticks SHALL be stable while res_valid=1 and res_ready=0.
REQ-029 When full, PEND channels SHALL wait without loss; new start/done on them follow REQ-021.

Reset
REQ-030 rst SHALL set timebase to 0, all channels to IDLE, FIFO empty (res_valid=0), res_ch=0, res_ticks=0, proto_err=0, round-robin pointer to NUM_CH-1 (so channel 0 has first priority).
REQ-031 rst asserted mid-measurement SHALL discard all in-flight timestamps and queued results with no error flagged.
REQ-032 Inputs in the reset cycle SHALL be ignored.

Structure
REQ-033 Shared package SHALL hold the channel-state encoding (IDLE=0, RUN=1, PEND=2) and the default NUM_CH, CNT_W, and FIFO_DEPTH constants.
REQ-034 The result FIFO SHALL be a sub-module named profile_fifo (parameterised width/depth, valid/ready output, full flag).
REQ-035 Round-robin arbiter and per-channel FSMs SHALL stay in cycle_profiler.

Verification
REQ-036 rst 3 cycles; start[0] at tick_now=10, done[0] at tick_now=25 -> one entry res_ch=0, res_ticks=15, res_valid 2 cycles after done.
REQ-037 start[1] at tick 5; freeze=1 for 7 cycles; done[1] 20 cycles after start -> res_ticks=13.
REQ-038 done on channels 0..3 in the same cycle, res_ready=1, pointer=3 -> entries in order ch0, ch1, ch2, ch3 on consecutive cycles.
REQ-039 res_ready=0, 6 channels-worth of results (NUM_CH=8) -> 4 entries queued, 2 channels held in PEND; raise res_ready -> all 6 drained, none lost.
REQ-040 start[2] twice without done; done[3] while IDLE -> proto_err=4'b1100, sticky until rst.
REQ-041 Timestamp 0xFFFF_FFF0, done 0x20 ticks later (wrapped) -> res_ticks=0x20; rst mid-RUN -> no entry produced.

Source files
------------

// File: rtl/cycle_profiler_pkg.sv
// Shared definitions for the cycle profiler: channel FSM encoding and the
// default sizing constants used by the top-level parameters.
package cycle_profiler_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_PEND = 2'd2
    } ch_state_e;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/cycle_profiler_fifo.sv
// Result FIFO for the cycle profiler: circular buffer with a valid/ready
// read side, a full flag for the writer, and simultaneous push/pop.
module profile_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign pop_valid = (count_q != {(AW + 1){1'b0}});
    assign pop_data  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop_valid && pop_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset clears the head so the outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cycle_profiler.sv
// Multi-channel latency profiler: per-channel start/done FSMs timed against a
// freezable timebase, results arbitrated round-robin into a result FIFO.
module cycle_profiler
    import cycle_profiler_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         done,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_ticks,
    output logic [NUM_CH-1:0]         proto_err,
    output logic [CNT_W-1:0]          tick_now
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int EW  = CHW + CNT_W;

    logic [CNT_W-1:0]  tick_q, tick_d;
    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  stamp_q [NUM_CH];
    logic [CNT_W-1:0]  stamp_d [NUM_CH];
    logic [CNT_W-1:0]  lat_q   [NUM_CH];
    logic [CNT_W-1:0]  lat_d   [NUM_CH];
    logic [NUM_CH-1:0] perr_q, perr_d;
    logic [CHW-1:0]    rr_q, rr_d;
    logic [CHW-1:0]    cand;
    logic [CHW-1:0]    grant_idx;
    logic              grant_vld;
    logic [NUM_CH-1:0] grant;
    logic              fifo_full;
    logic [EW-1:0]     fifo_wdata;
    logic [EW-1:0]     fifo_rdata;

    // Timebase: wraps naturally, holds while frozen.
    always_comb begin
        if (freeze) begin
            tick_d = tick_q;
        end else begin
            tick_d = tick_q + CNT_W'(1);
        end
    end

    // Round-robin grant among PEND channels, searching from last grant + 1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = rr_q;
        grant     = {NUM_CH{1'b0}};
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = CHW'((int'(rr_q) + off) % NUM_CH);
            if (!grant_vld && !fifo_full && (state_q[cand] == CH_PEND)) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end else begin
                grant_idx = grant_idx;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
            rr_d             = grant_idx;
        end else begin
            grant = {NUM_CH{1'b0}};
            rr_d  = rr_q;
        end
    end

    // Per-channel FSMs; out-of-protocol pulses are dropped and latched as errors.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            stamp_d[i] = stamp_q[i];
            lat_d[i]   = lat_q[i];
            perr_d[i]  = perr_q[i];
            case (state_q[i])
                CH_IDLE: begin
                    if (start[i] && done[i]) begin
                        state_d[i] = CH_PEND;
                        lat_d[i]   = {CNT_W{1'b0}};
                    end else if (start[i]) begin
                        state_d[i] = CH_RUN;
                        stamp_d[i] = tick_q;
                    end else if (done[i]) begin
                        perr_d[i] = 1'b1;
                    end else begin
                        state_d[i] = CH_IDLE;
                    end
                end
                CH_RUN: begin
                    if (start[i]) begin
                        perr_d[i] = 1'b1;
                    end else begin
                        perr_d[i] = perr_q[i];
                    end
                    if (done[i]) begin
                        state_d[i] = CH_PEND;
                        lat_d[i]   = tick_q - stamp_q[i];
                    end else begin
                        state_d[i] = CH_RUN;
                    end
                end
                CH_PEND: begin
                    if (start[i] || done[i]) begin
                        perr_d[i] = 1'b1;
                    end else begin
                        perr_d[i] = perr_q[i];
                    end
                    if (grant[i]) begin
                        state_d[i] = CH_IDLE;
                    end else begin
                        state_d[i] = CH_PEND;
                    end
                end
                default: begin
                    state_d[i] = CH_IDLE;
                end
            endcase
        end
    end

    // Profiler state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= {CNT_W{1'b0}};
            perr_q <= {NUM_CH{1'b0}};
            rr_q   <= CHW'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                stamp_q[i] <= {CNT_W{1'b0}};
                lat_q[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            tick_q  <= tick_d;
            perr_q  <= perr_d;
            rr_q    <= rr_d;
            state_q <= state_d;
            stamp_q <= stamp_d;
            lat_q   <= lat_d;
        end
    end

    assign fifo_wdata = {grant_idx, lat_q[grant_idx]};

    profile_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_vld),
        .push_data (fifo_wdata),
        .full      (fifo_full),
        .pop_valid (res_valid),
        .pop_ready (res_ready),
        .pop_data  (fifo_rdata)
    );

    assign res_ch    = fifo_rdata[EW-1 -: CHW];
    assign res_ticks = fifo_rdata[CNT_W-1:0];
    assign proto_err = perr_q;
    assign tick_now  = tick_q;

endmodule

// File: tb/tb_cycle_profiler.sv
// Scoreboard bench for cycle_profiler with 8 channels and a narrowed 8-bit
// timebase so that wrap-around is reachable in a short run.
module tb_cycle_profiler;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] ticks;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic [7:0] start;
    logic [7:0] done;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_ch;
    logic [7:0] res_ticks;
    logic [7:0] proto_err;
    logic [7:0] tick_now;

    logic [7:0] model_tick;
    exp_t       exp_q[$];
    int         n_pass;
    int         n_total;

    cycle_profiler #(
        .NUM_CH     (8),
        .CNT_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .start     (start),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_ticks (res_ticks),
        .proto_err (proto_err),
        .tick_now  (tick_now)
    );

    always #5 clk = ~clk;

    // One clock: update the timebase model, then clear the one-cycle pulses.
    task automatic tick_cycle();
        @(posedge clk);
        if (rst) model_tick = 8'd0;
        else if (!freeze) model_tick = model_tick + 8'd1;
        else model_tick = model_tick;
        #1;
        start = 8'd0;
        done  = 8'd0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) tick_cycle();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else n_pass++;
        n_total++; if (res_ch !== 3'd0) $display("FAIL reset_ch: got %0d want 0", res_ch); else n_pass++;
        n_total++; if (res_ticks !== 8'd0) $display("FAIL reset_ticks: got %0h want 0", res_ticks); else n_pass++;
        n_total++; if (proto_err !== 8'd0) $display("FAIL reset_err: got %b want 0", proto_err); else n_pass++;
        n_total++; if (tick_now !== 8'd0) $display("FAIL reset_tick: got %0d want 0", tick_now); else n_pass++;
        repeat (5) tick_cycle();
        n_total++; if (tick_now !== model_tick) $display("FAIL tick_count: got %0d want %0d", tick_now, model_tick); else n_pass++;
    endtask

    task automatic test_basic();
        exp_t e;
        res_ready = 1'b1;
        apply_reset();
        while (model_tick != 8'd10) tick_cycle();
        start[0] = 1'b1;
        while (model_tick != 8'd25) tick_cycle();
        done[0] = 1'b1;
        exp_q.push_back(exp_t'{3'd0, 8'd15});
        tick_cycle();
        n_total++; if (res_valid !== 1'b0) $display("FAIL basic_early: got %b want 0", res_valid); else n_pass++;
        tick_cycle();
        e = exp_q.pop_front();
        n_total++; if (res_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", res_valid); else n_pass++;
        n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
            $display("FAIL basic_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
        tick_cycle();
        n_total++; if (res_valid !== 1'b0) $display("FAIL basic_popped: got %b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_freeze();
        exp_t e;
        res_ready = 1'b1;
        apply_reset();
        while (model_tick != 8'd5) tick_cycle();
        start[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick_cycle();
            freeze = (i >= 3 && i <= 9);
            if (i == 20) done[1] = 1'b1;
        end
        n_total++; if (tick_now !== model_tick) $display("FAIL freeze_tick: got %0d want %0d", tick_now, model_tick); else n_pass++;
        exp_q.push_back(exp_t'{3'd1, 8'd13});
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
                    $display("FAIL freeze_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
            end
            tick_cycle();
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL freeze_drain: %0d entries missing, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        res_ready = 1'b1;
        apply_reset();
        repeat (2) tick_cycle();
        start = 8'h0F;
        repeat (6) tick_cycle();
        done = 8'h0F;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{3'(i), 8'd6});
        tick_cycle();
        n_total++; if (res_valid !== 1'b0) $display("FAIL b2b_early: got %b want 0", res_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick_cycle();
            e = exp_q.pop_front();
            n_total++; if (res_valid !== 1'b1) $display("FAIL b2b_valid: slot %0d got %b want 1", i, res_valid); else n_pass++;
            n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
                $display("FAIL b2b_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
        end
        tick_cycle();
        n_total++; if (res_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_zero_latency();
        exp_t e;
        res_ready = 1'b1;
        apply_reset();
        repeat (3) tick_cycle();
        start[4] = 1'b1;
        done[4]  = 1'b1;
        exp_q.push_back(exp_t'{3'd4, 8'd0});
        tick_cycle();
        n_total++; if (res_valid !== 1'b0) $display("FAIL zero_early: got %b want 0", res_valid); else n_pass++;
        tick_cycle();
        e = exp_q.pop_front();
        n_total++; if (res_valid !== 1'b1) $display("FAIL zero_valid: got %b want 1", res_valid); else n_pass++;
        n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
            $display("FAIL zero_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
        n_total++; if (proto_err !== 8'd0) $display("FAIL zero_err: got %b want 0", proto_err); else n_pass++;
    endtask

    task automatic test_full();
        exp_t e;
        res_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            start[i] = 1'b1;
            tick_cycle();
        end
        while (model_tick != 8'd10) tick_cycle();
        done = 8'h3F;
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_t'{3'(i), 8'(10 - i)});
        repeat (8) tick_cycle();
        n_total++; if (res_valid !== 1'b1) $display("FAIL full_valid: got %b want 1", res_valid); else n_pass++;
        n_total++; if ({res_ch, res_ticks} !== {exp_q[0].ch, exp_q[0].ticks})
            $display("FAIL full_head: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, exp_q[0].ch, exp_q[0].ticks); else n_pass++;
        start[4] = 1'b1;
        done[5]  = 1'b1;
        repeat (2) tick_cycle();
        n_total++; if (proto_err !== 8'h30) $display("FAIL full_held_err: got %b want 00110000", proto_err); else n_pass++;
        n_total++; if ({res_ch, res_ticks} !== {exp_q[0].ch, exp_q[0].ticks})
            $display("FAIL full_stable: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, exp_q[0].ch, exp_q[0].ticks); else n_pass++;
        res_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
                    $display("FAIL full_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
            end
            tick_cycle();
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL full_drain: %0d entries missing, want 0", exp_q.size()); else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL full_extra: got %b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_proto();
        exp_t e;
        res_ready = 1'b1;
        apply_reset();
        start[2] = 1'b1;
        tick_cycle();
        start[2] = 1'b1;
        tick_cycle();
        done[3] = 1'b1;
        tick_cycle();
        n_total++; if (proto_err !== 8'h0C) $display("FAIL proto_set: got %b want 00001100", proto_err); else n_pass++;
        repeat (5) tick_cycle();
        n_total++; if (proto_err !== 8'h0C) $display("FAIL proto_sticky: got %b want 00001100", proto_err); else n_pass++;
        done[2] = 1'b1;
        exp_q.push_back(exp_t'{3'd2, model_tick});
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
                    $display("FAIL proto_entry: got ch%0d/%0d want ch%0d/%0d", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
            end
            tick_cycle();
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL proto_drain: %0d entries missing, want 0", exp_q.size()); else n_pass++;
        n_total++; if (proto_err !== 8'h0C) $display("FAIL proto_keep: got %b want 00001100", proto_err); else n_pass++;
        apply_reset();
        n_total++; if (proto_err !== 8'd0) $display("FAIL proto_clear: got %b want 0", proto_err); else n_pass++;
        n_total++; if ({res_ch, res_ticks} !== 11'd0) $display("FAIL proto_head_clear: got ch%0d/%0d want ch0/0", res_ch, res_ticks); else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   saw_valid;
        res_ready = 1'b1;
        apply_reset();
        while (model_tick != 8'hF0) tick_cycle();
        start[0] = 1'b1;
        while (model_tick != 8'h10) tick_cycle();
        done[0] = 1'b1;
        exp_q.push_back(exp_t'{3'd0, 8'h20});
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if ({res_ch, res_ticks} !== {e.ch, e.ticks})
                    $display("FAIL wrap_entry: got ch%0d/%0h want ch%0d/%0h", res_ch, res_ticks, e.ch, e.ticks); else n_pass++;
            end
            tick_cycle();
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL wrap_drain: %0d entries missing, want 0", exp_q.size()); else n_pass++;
        n_total++; if (tick_now !== model_tick) $display("FAIL wrap_tick: got %0h want %0h", tick_now, model_tick); else n_pass++;
        // Leave ch1 mid-run and one result queued, then reset over them.
        res_ready = 1'b0;
        start[1] = 1'b1;
        tick_cycle();
        start[5] = 1'b1;
        done[5]  = 1'b1;
        repeat (3) tick_cycle();
        rst      = 1'b1;
        start[3] = 1'b1;
        tick_cycle();
        rst = 1'b0;
        n_total++; if (tick_now !== 8'd0) $display("FAIL wrap_rst_tick: got %0d want 0", tick_now); else n_pass++;
        done[3]   = 1'b1;
        res_ready = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick_cycle();
            if (res_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid) $display("FAIL rst_discard: got res_valid 1 after reset want 0"); else n_pass++;
        n_total++; if (proto_err !== 8'h08) $display("FAIL rst_ignore: got %b want 00001000", proto_err); else n_pass++;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        freeze     = 1'b0;
        start      = 8'd0;
        done       = 8'd0;
        res_ready  = 1'b0;
        model_tick = 8'd0;
        n_pass     = 0;
        n_total    = 0;
        test_reset();
        test_basic();
        test_freeze();
        test_back_to_back();
        test_zero_latency();
        test_full();
        test_proto();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
